// File: rtl/baud_control.sv
// baud_control: divides clk by a BC-selected divisor and emits a one-cycle ena pulse per baud period
module baud_control #(
  parameter int CNT_W = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] BC,
  output logic       ena
);
  logic [2:0]       bc_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  always_comb
    div_m1 = bc_q == 3'b001 ? CNT_W'(216) :
             bc_q == 3'b010 ? CNT_W'(108) :
             bc_q == 3'b011 ? CNT_W'(71)  :
             bc_q == 3'b100 ? CNT_W'(35)  : CNT_W'(433);
  // a select change restarts the period and suppresses any coincident pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bc_q <= '0;
      cnt  <= '0;
      ena  <= 1'b0;
    end else if (BC != bc_q) begin
      bc_q <= BC;
      cnt  <= '0;
      ena  <= 1'b0;
    end else if (cnt == div_m1) begin
      cnt <= '0;
      ena <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      ena <= 1'b0;
    end
endmodule

// File: tb/tb_baud_control.sv
// tb_baud_control: checks ena against a model that knows only restart edges and the divisor table
module tb_baud_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] BC  = 3'b000;
  logic       ena;
  int         total = 0;
  int         bad = 0;
  int         edge_n = 0;
  int         t0 = 0;
  int         d = 434;
  logic [2:0] sel = 3'b000;
  logic       exp_ena = 1'b0;

  baud_control #(.CNT_W(9)) dut (.clk(clk), .rst(rst), .BC(BC), .ena(ena));

  always #5 clk = ~clk;

  function automatic int div_of(input logic [2:0] s);
    case (s)
      3'b001:  return 217;
      3'b010:  return 109;
      3'b011:  return 72;
      3'b100:  return 36;
      default: return 434;
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // a pulse is due every d edges counted from the last restart (reset or select change)
  task automatic step();
    @(posedge clk);
    edge_n++;
    if (rst) begin
      sel = 3'b000; d = 434; t0 = edge_n; exp_ena = 1'b0;
    end else if (BC != sel) begin
      sel = BC; d = div_of(BC); t0 = edge_n; exp_ena = 1'b0;
    end else
      exp_ena = ((edge_n - t0) % d) == 0;
    #1 chk("ena_model", ena, exp_ena);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic gap(input string tag, input int want);
    int n = 0;
    do begin
      step();
      n++;
    end while (ena !== 1'b1 && n < 2000);
    total++;
    assert (n == want && ena === 1'b1) else begin
      bad++;
      $error("FAIL %s observed_edges=%0d expected_edges=%0d", tag, n, want);
    end
  endtask

  initial begin
    logic [2:0] codes [7] = '{3'b011, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    run(3);
    chk("reset_ena", ena, 1'b0);
    #2 rst = 1'b0;
    gap("first_434", 434);
    gap("second_434", 434);
    gap("third_434", 434);
    foreach (codes[i]) begin
      #1 BC = codes[i];
      step();
      gap($sformatf("first_bc%0d", codes[i]), div_of(codes[i]));
      gap($sformatf("period_bc%0d", codes[i]), div_of(codes[i]));
      gap($sformatf("period2_bc%0d", codes[i]), div_of(codes[i]));
    end
    BC = 3'b000;
    step();
    while ((edge_n + 1 - t0) % d != 0) step();
    BC = 3'b100;
    step();
    chk("coincide_no_pulse", ena, 1'b0);
    gap("after_coincide", 36);
    BC = 3'b001;
    step();
    run(50);
    #3 rst = 1'b1;
    #1 chk("async_rst_ena", ena, 1'b0);
    total++;
    assert (dut.cnt === 9'd0) else begin
      bad++;
      $error("FAIL async_rst_cnt observed=%0d expected=0", dut.cnt);
    end
    run(2);
    #2 rst = 1'b0;
    step();
    gap("post_reset_217", 217);
    chk("pulse_before_rst", ena, 1'b1);
    #1 rst = 1'b1;
    #1 chk("rst_drops_ena", ena, 1'b0);
    step();
    #2 rst = 1'b0;
    repeat (25) begin
      BC = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        step();
        #2 rst = 1'b0;
      end
      run($urandom_range(1, 900));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
